// File: rtl/cnn1d_pkg.sv
// cnn1d_pkg: shared types for the cnn1d classifier and its verdict sink.
package cnn1d_pkg;

   typedef enum logic [1:0] {VS_ACCUM, VS_DECIDE, VS_PRESENT} verdict_state_t;

endpackage

// File: rtl/cnn1d_verdict_sink.sv
// cnn1d_verdict_sink: windowed majority vote over the cnn1d class stream.
module cnn1d_verdict_sink
   import cnn1d_pkg::*;
#(
   parameter int NUM_CLASSES = 2,
   parameter int CLASS_WIDTH = 1,
   parameter int WINDOW_SIZE = 16,
   parameter int COUNT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cond_valid_in,
   input  logic [CLASS_WIDTH-1:0] cond_data_in,
   output logic                   cond_ready_out,
   input  logic                   flush_in,
   output logic                   verdict_valid_out,
   output logic [CLASS_WIDTH-1:0] verdict_class_out,
   output logic [COUNT_WIDTH-1:0] verdict_votes_out,
   output logic [COUNT_WIDTH-1:0] verdict_total_out,
   input  logic                   verdict_ready_in,
   output logic [15:0]            err_count_out
);

   localparam int SW = $clog2(NUM_CLASSES + 1);

   verdict_state_t state;
   logic [COUNT_WIDTH-1:0] tally [NUM_CLASSES];
   logic [COUNT_WIDTH-1:0] total, total_nx, best_votes, cur;
   logic [CLASS_WIDTH-1:0] best_idx;
   logic [SW-1:0]          scan;
   logic [15:0]            err_count;
   logic                   xfer, in_range, good;

   assign cond_ready_out    = state == VS_ACCUM && !rst;
   assign xfer              = cond_valid_in && cond_ready_out;
   assign in_range          = {1'b0, cond_data_in} < (CLASS_WIDTH + 1)'(NUM_CLASSES);
   assign good              = xfer && in_range;
   assign total_nx          = total + COUNT_WIDTH'(good);
   assign verdict_valid_out = state == VS_PRESENT;
   assign verdict_class_out = verdict_valid_out ? best_idx : '0;
   assign verdict_votes_out = verdict_valid_out ? best_votes : '0;
   assign verdict_total_out = verdict_valid_out ? total : '0;
   assign err_count_out     = err_count;

   // tally of the class currently under the argmax scan
   always_comb begin
      cur = '0;
      for (int i = 0; i < NUM_CLASSES; i++)
         if (scan == SW'(i)) cur = tally[i];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= VS_ACCUM;
         total      <= '0;
         err_count  <= '0;
         scan       <= '0;
         best_idx   <= '0;
         best_votes <= '0;
         for (int i = 0; i < NUM_CLASSES; i++) tally[i] <= '0;
      end else begin
         case (state)
            VS_ACCUM: begin
               if (good) begin
                  total <= total_nx;
                  for (int i = 0; i < NUM_CLASSES; i++)
                     if (cond_data_in == CLASS_WIDTH'(i)) tally[i] <= tally[i] + 1'b1;
               end
               if (xfer && !in_range && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
               // a same-cycle transfer is counted before flush looks at the total
               if ((good && total_nx == COUNT_WIDTH'(WINDOW_SIZE)) || (flush_in && total_nx != '0)) begin
                  state      <= VS_DECIDE;
                  scan       <= '0;
                  best_idx   <= '0;
                  best_votes <= '0;
               end
            end
            VS_DECIDE: begin
               if (scan == SW'(NUM_CLASSES)) state <= VS_PRESENT;
               else begin
                  if (cur > best_votes) begin
                     best_votes <= cur;
                     best_idx   <= CLASS_WIDTH'(scan);
                  end
                  scan <= scan + 1'b1;
               end
            end
            VS_PRESENT: begin
               if (verdict_ready_in) begin
                  state <= VS_ACCUM;
                  total <= '0;
                  for (int i = 0; i < NUM_CLASSES; i++) tally[i] <= '0;
               end
            end
            default: state <= VS_ACCUM;
         endcase
      end
   end

endmodule
